// File: rtl/pio_input_edge.sv
// pio_input_edge: Avalon-MM slave input port with edge capture and a level interrupt.
//
// An external WIDTH-bit bus is passed through a two-flop synchroniser. Edges seen between
// the two stages are latched per bit in an edge-capture register. Software clears capture
// bits by writing 1s. A maskable level interrupt is raised while any unmasked capture bit
// is set. Read data is registered, giving a fixed 1-cycle read latency.
//
// Register map (word addresses, bits above WIDTH read 0):
//   0 DATA          read-only, synchronised input value
//   1 IRQ_MASK      read/write
//   2 reserved      reads 0
//   3 EDGE_CAPTURE  read, write-1-to-clear
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register word address
//   chipselect  slave select, qualifies writes
//   write_n     active-low write strobe
//   writedata   write data
//   in_port     asynchronous external inputs
//   readdata    registered read data
//   irq         active-high level interrupt
module pio_input_edge #(
   parameter int unsigned     WIDTH          = 8,
   parameter int unsigned     EDGE_MODE      = 0,
   parameter logic [WIDTH-1:0] SYNC_RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] s1_q, s2_q;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] capture_q, capture_d;
   logic [31:0]      readdata_q, readdata_d;

   logic [WIDTH-1:0] rise, fall, ev, clr, rd_mux;
   logic             wr;

   assign wr = chipselect & ~write_n;

   // Edges are detected between the two synchroniser stages so s1 is never used
   // metastable-fresh by more than this one comparison.
   assign rise = s1_q & ~s2_q;
   assign fall = ~s1_q & s2_q;

   always_comb begin
      ev = rise;
      case (EDGE_MODE)
         1:       ev = fall;
         2:       ev = rise | fall;
         default: ev = rise;
      endcase
   end

   always_comb begin
      mask_d = mask_q;
      clr    = '0;
      if (wr && (address == 2'd1)) begin
         mask_d = writedata[WIDTH-1:0];
      end
      if (wr && (address == 2'd3)) begin
         clr = writedata[WIDTH-1:0];
      end
      // OR-ing ev after the clear makes a new edge win over a same-cycle clear.
      capture_d = (capture_q & ~clr) | ev;
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         2'd0:    rd_mux = s2_q;
         2'd1:    rd_mux = mask_q;
         2'd3:    rd_mux = capture_q;
         default: rd_mux = '0;
      endcase
      readdata_d = 32'(rd_mux);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q       <= SYNC_RESET_VAL;
         s2_q       <= SYNC_RESET_VAL;
         mask_q     <= '0;
         capture_q  <= '0;
         readdata_q <= '0;
      end else begin
         s1_q       <= in_port;
         s2_q       <= s1_q;
         mask_q     <= mask_d;
         capture_q  <= capture_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   // Pure function of flops, so it cannot glitch on bus activity.
   assign irq = |(capture_q & mask_q);

   // Write-data bits above WIDTH are ignored by design.
   if (WIDTH < 32) begin : g_unused_wdata
      logic unused_wdata;
      assign unused_wdata = ^writedata[31:WIDTH];
   end

endmodule

// File: tb/tb_pio_input_edge.sv
// Directed bench for pio_input_edge: four instances share one bus (rising, falling,
// any-edge at WIDTH 8, and rising at WIDTH 12), each with its own input and outputs.
module tb_pio_input_edge;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;

   logic [7:0]  in_r, in_f, in_a;
   logic [11:0] in_w;
   logic [31:0] rd_r, rd_f, rd_a, rd_w;
   logic        irq_r, irq_f, irq_a, irq_w;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pio_input_edge #(.WIDTH(8), .EDGE_MODE(0), .SYNC_RESET_VAL(8'h00)) u_r (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_r), .readdata(rd_r), .irq(irq_r)
   );
   pio_input_edge #(.WIDTH(8), .EDGE_MODE(1), .SYNC_RESET_VAL(8'h00)) u_f (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_f), .readdata(rd_f), .irq(irq_f)
   );
   pio_input_edge #(.WIDTH(8), .EDGE_MODE(2), .SYNC_RESET_VAL(8'h00)) u_a (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_a), .readdata(rd_a), .irq(irq_a)
   );
   pio_input_edge #(.WIDTH(12), .EDGE_MODE(0), .SYNC_RESET_VAL(12'h000)) u_w (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_w), .readdata(rd_w), .irq(irq_w)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // All tasks start and end 1 time unit after a rising edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick(1);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [1:0] a);
      address = a;
      tick(1);
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_r       = 8'hFF;
      in_f       = 8'hF0;
      in_a       = 8'h00;
      in_w       = 12'h000;

      // Reset
      tick(3);
      check_eq("reset_readdata", rd_r, 32'h0);
      check_eq("reset_irq", {31'b0, irq_r}, 32'h0);
      reset_n = 1'b1;
      tick(3);
      bus_read(2'd0);
      check_eq("data_after_reset", rd_r, 32'h0000_00FF);
      bus_read(2'd3);
      check_eq("reset_release_artefact", rd_r, 32'h0000_00FF);

      // Rising capture
      bus_write(2'd3, 32'hFF);
      bus_read(2'd3);
      check_eq("capture_cleared", rd_r, 32'h0);
      in_r = 8'h00;
      tick(3);
      bus_write(2'd3, 32'hFF);
      in_r = 8'h05;
      tick(3);
      bus_read(2'd3);
      check_eq("rise_capture", rd_r, 32'h0000_0005);
      in_r = 8'h00;
      tick(3);
      bus_read(2'd3);
      check_eq("rise_ignores_fall", rd_r, 32'h0000_0005);
      check_eq("irq_masked_off", {31'b0, irq_r}, 32'h0);

      // Interrupt path
      bus_write(2'd1, 32'h04);
      check_eq("irq_on_mask_set", {31'b0, irq_r}, 32'h1);
      bus_read(2'd1);
      check_eq("mask_readback", rd_r, 32'h0000_0004);
      bus_write(2'd3, 32'h04);
      check_eq("irq_off_after_w1c", {31'b0, irq_r}, 32'h0);
      bus_read(2'd3);
      check_eq("capture_after_w1c", rd_r, 32'h0000_0001);
      bus_write(2'd1, 32'h01);
      check_eq("irq_on_mask_bit0", {31'b0, irq_r}, 32'h1);
      bus_write(2'd1, 32'h00);
      check_eq("irq_off_mask_clear", {31'b0, irq_r}, 32'h0);

      // Set beats clear: the W1C lands on the edge where bit 1 is captured
      in_r = 8'h02;
      tick(1);
      bus_write(2'd3, 32'h02);
      bus_read(2'd3);
      check_eq("set_beats_clear", rd_r, 32'h0000_0003);
      bus_write(2'd3, 32'h02);
      bus_read(2'd3);
      check_eq("plain_w1c_bit1", rd_r, 32'h0000_0001);

      // Falling and any-edge modes
      bus_write(2'd3, 32'hFF);
      in_f = 8'h30;
      tick(3);
      bus_read(2'd3);
      check_eq("fall_capture", rd_f, 32'h0000_00C0);
      in_a = 8'h01;
      tick(3);
      bus_read(2'd3);
      check_eq("any_rise", rd_a, 32'h0000_0001);
      bus_write(2'd3, 32'hFF);
      in_f = 8'hF0;
      in_a = 8'h00;
      tick(3);
      bus_read(2'd3);
      check_eq("any_fall", rd_a, 32'h0000_0001);
      check_eq("fall_ignores_rise", rd_f, 32'h0);

      // WIDTH 12 and register map
      bus_write(2'd3, 32'hFFFF_FFFF);
      in_w = 12'hABC;
      tick(3);
      bus_read(2'd0);
      check_eq("w12_data", rd_w, 32'h0000_0ABC);
      bus_read(2'd2);
      check_eq("w12_reserved", rd_w, 32'h0);
      check_eq("w8_reserved", rd_r, 32'h0);
      bus_write(2'd1, 32'hFFFF_FFFF);
      check_eq("w12_irq", {31'b0, irq_w}, 32'h1);
      bus_read(2'd1);
      check_eq("w12_mask_trunc", rd_w, 32'h0000_0FFF);
      check_eq("w8_mask_trunc", rd_r, 32'h0000_00FF);
      address    = 2'd1;
      writedata  = 32'h0;
      chipselect = 1'b0;
      write_n    = 1'b0;
      tick(1);
      write_n    = 1'b1;
      bus_read(2'd1);
      check_eq("no_cs_no_write", rd_w, 32'h0000_0FFF);
      bus_write(2'd0, 32'h0);
      bus_read(2'd0);
      check_eq("data_write_ignored", rd_w, 32'h0000_0ABC);
      bus_read(2'd3);
      check_eq("w12_capture", rd_w, 32'h0000_0ABC);

      // Reset mid-operation
      reset_n = 1'b0;
      #1;
      check_eq("midreset_irq", {31'b0, irq_w}, 32'h0);
      check_eq("midreset_readdata", rd_w, 32'h0);
      tick(1);
      reset_n = 1'b1;
      address = 2'd1;
      tick(1);
      check_eq("midreset_mask", rd_w, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pio_input_edge.md
Name: pio_input_edge

Overview:
- Parametrised Avalon-MM slave input port; successor to the fixed 8-bit read-only input port.
- Samples an external WIDTH-bit bus (e.g. NES controller button lines) through a 2-flop synchroniser.
- Latches per-bit edge events in a capture register and raises a maskable level interrupt to the Nios II.
- Readdata is registered with a fixed 1-cycle read latency, the same as the existing input port.

Parameters:
- WIDTH, 8, number of input bits; legal range 1..32.
- EDGE_MODE, 0, edge type captured: 0 = rising, 1 = falling, 2 = any; other values behave as 0.
- SYNC_RESET_VAL, 0, WIDTH-bit reset value loaded into both synchroniser stages.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  2  word address of the register to access.
- chipselect  input  1  slave select; qualifies writes.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- in_port  input  WIDTH  asynchronous external inputs.
- readdata  output  32  registered read data.
- irq  output  1  level interrupt, active high.

Behaviour:
- Reset (asynchronous): s1 = s2 = SYNC_RESET_VAL; irq_mask = 0; edge_capture = 0; readdata = 0; irq = 0. Deassertion is not synchronised internally.
- Synchroniser: s1 <= in_port and s2 <= s1 on every clk edge.
- Edge detect (combinational): rise = s1 & ~s2; fall = ~s1 & s2; ev = rise, fall, or (rise | fall) per EDGE_MODE.
- Timing: in_port changes before edge k -> s1 updates at k -> edge_capture bit sets at k+1 and s2 updates at k+1 -> irq is high in the cycle after k+1.
- Register map (bits above WIDTH read 0 and ignore writes):
  - addr 0: DATA, read-only, returns s2; writes ignored.
  - addr 1: IRQ_MASK, read/write, WIDTH bits.
  - addr 2: reserved, reads 0, writes ignored.
  - addr 3: EDGE_CAPTURE, read; write-1-to-clear per bit.
- Write strobe: wr = chipselect & ~write_n. The write takes effect at the clk edge where wr is high.
- Capture update: edge_capture <= (edge_capture & ~clr) | ev, where clr = writedata[WIDTH-1:0] when wr and address == 3, else 0.
- Simultaneous edge and clear on the same bit: set wins, so the bit stays 1.
- Read path: readdata <= zero-extended mux(address) on every clk, independent of chipselect, giving 1-cycle latency. Reading has no side effects; a read does not clear capture bits.
- irq = |(edge_capture & irq_mask), driven from registers only, glitch-free.
  - Clearing the mask deasserts irq the cycle after the write.
  - Setting the mask with a pending capture asserts irq the cycle after the write.
- Constant input: no events after the synchroniser settles.
- Reset-release artefact: if in_port is held differently from SYNC_RESET_VAL at reset release, the resulting edge is captured 2 cycles after release. This is intended; software clears it at init.
- Reset mid-operation: all state clears immediately, including pending capture bits and irq.

Test Plan:
- Reset: hold reset_n = 0 with in_port = 8'hFF and SYNC_RESET_VAL = 0 -> readdata = 0, irq = 0. Release reset, wait 3 cycles, read addr 0 -> readdata = 32'h000000FF.
- Rising capture (EDGE_MODE = 0): after init, write addr 3 = 8'hFF to clear; set in_port 8'h00 -> 8'h05 -> addr 3 reads 32'h00000005. Return in_port to 8'h00 -> addr 3 still 32'h00000005.
- Interrupt path: set IRQ_MASK = 8'h04 with capture = 8'h05 -> irq = 1 one cycle after the write. Write addr 3 = 8'h04 -> irq = 0 next cycle and addr 3 reads 32'h00000001.
- Set-beats-clear: drive a rising edge on bit 1 timed to the same clk edge as a W1C write of 8'h02 to addr 3 -> bit 1 of addr 3 reads 1.
- Modes: EDGE_MODE = 1 with in_port 8'hF0 -> 8'h30 -> capture reads 8'hC0. EDGE_MODE = 2 with 8'h00 -> 8'h01 -> 8'h00 -> capture reads 8'h01.
- Width/map: WIDTH = 12, in_port = 12'hABC -> addr 0 reads 32'h00000ABC. Addr 2 reads 0. Write IRQ_MASK = 32'hFFFFFFFF -> reads back 32'h00000FFF. chipselect = 0 writes have no effect.
